// File: rtl/block_transfer_sequencer.sv
// Load/store-multiple sequencer: walks a register list and moves one
// word per register between the register file and data memory.
module block_transfer_sequencer #(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         load,
  input  logic         wb,
  input  logic [N-1:0] base_reg,
  input  logic [M-1:0] base_addr,
  input  logic [15:0]  reg_list,
  output logic [N-1:0] rf_a1,
  input  logic [M-1:0] rf_rd1,
  output logic         rf_we3,
  output logic [N-1:0] rf_a3,
  output logic [M-1:0] rf_wd3,
  output logic         pc_we,
  output logic [M-1:0] pc_wd,
  output logic         mem_req,
  output logic         mem_we,
  output logic [M-1:0] mem_addr,
  output logic [M-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [M-1:0] mem_rdata,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE, ISSUE, LWRITE, WBASE, DONE
  } state_t;

  state_t state, nstate;

  logic         ld, wbl;
  logic [N-1:0] breg, cur, lcur;
  logic [15:0]  rem, orig, rem_clr;
  logic [M-1:0] addr, base, data;
  logic [4:0]   cnt;
  logic         skip_wb;

  always_comb begin
    cur = '0;
    for (int i = 15; i >= 0; i--)
      if (rem[i]) cur = N'(i);
  end

  assign rem_clr = rem & ~(16'd1 << cur);

  // a loaded base register keeps the loaded value
  assign skip_wb = !wbl || (breg == N'(15)) ||
                   (ld && orig[breg]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:
        if (start)
          nstate = (reg_list == '0) ? DONE : ISSUE;
      ISSUE:
        if (mem_ack) begin
          if (ld)
            nstate = LWRITE;
          else if (rem_clr != '0)
            nstate = ISSUE;
          else
            nstate = skip_wb ? DONE : WBASE;
        end
      LWRITE:
        if (rem != '0)
          nstate = ISSUE;
        else
          nstate = skip_wb ? DONE : WBASE;
      WBASE:   nstate = DONE;
      DONE:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld   <= 1'b0;
      wbl  <= 1'b0;
      breg <= '0;
      rem  <= '0;
      orig <= '0;
      addr <= '0;
      base <= '0;
      cnt  <= '0;
      data <= '0;
      lcur <= '0;
    end else begin
      if (state == IDLE && start) begin
        ld   <= load;
        wbl  <= wb;
        breg <= base_reg;
        rem  <= reg_list;
        orig <= reg_list;
        addr <= base_addr;
        base <= base_addr;
        cnt  <= 5'($countones(reg_list));
      end
      if (state == ISSUE && mem_ack) begin
        rem  <= rem_clr;
        addr <= addr + M'(4);
        data <= mem_rdata;
        lcur <= cur;
      end
    end
  end

  always_comb begin
    rf_a1     = '0;
    rf_we3    = 1'b0;
    rf_a3     = '0;
    rf_wd3    = '0;
    pc_we     = 1'b0;
    pc_wd     = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != IDLE);
    done      = 1'b0;
    unique case (state)
      ISSUE: begin
        rf_a1     = cur;
        mem_req   = 1'b1;
        mem_we    = ~ld;
        mem_addr  = addr;
        mem_wdata = rf_rd1;
      end
      LWRITE: begin
        if (lcur == N'(15)) begin
          pc_we = 1'b1;
          pc_wd = data & ~M'(3);
        end else begin
          rf_we3 = 1'b1;
          rf_a3  = lcur;
          rf_wd3 = data;
        end
      end
      WBASE: begin
        rf_we3 = 1'b1;
        rf_a3  = breg;
        rf_wd3 = base + M'({cnt, 2'b00});
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Bench for block_transfer_sequencer: register file and memory models
// with a scoreboard of expected memory, register and done events.
module tb_block_transfer_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, load, wb;
  logic [3:0]  base_reg;
  logic [31:0] base_addr;
  logic [15:0] reg_list;
  logic [3:0]  rf_a1, rf_a3;
  logic [31:0] rf_rd1, rf_wd3, pc_wd;
  logic        rf_we3, pc_we;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, done;

  block_transfer_sequencer #(.N(4), .M(32)) dut (
    .clk(clk), .reset(reset), .start(start), .load(load),
    .wb(wb), .base_reg(base_reg), .base_addr(base_addr),
    .reg_list(reg_list), .rf_a1(rf_a1), .rf_rd1(rf_rd1),
    .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
    .pc_we(pc_we), .pc_wd(pc_wd), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t sb[$];

  logic [31:0] regs [16] = '{
    32'h00, 32'h11, 32'h22, 32'h33, 32'h44, 32'h55,
    32'h66, 32'h77, 32'h88, 32'h99, 32'haa, 32'hbb,
    32'hcc, 32'hdd, 32'hee, 32'hff
  };
  bit [31:0] mem [bit [31:0]];

  int nchk = 0, nerr = 0;
  int cyc = 0, start_cyc = 0;
  int busy_tot = 0, busy0 = 0;
  int done_cnt = 0, n_ack = 0;
  int dly = 0, wcnt = 0;
  logic force_ack = 1'b0;
  logic [31:0] h_addr, h_wd;
  logic h_we;

  assign rf_rd1 = regs[rf_a1];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] bg(input logic [31:0] a);
    case (a)
      32'h200: return 32'h0000000a;
      32'h204: return 32'h0000000b;
      32'h208: return 32'h00001237;
      default: return a ^ 32'h5a5a0000;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : bg(a);
  endfunction

  task automatic push(input int k, input logic [31:0] a,
                      input logic [31:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d;
    sb.push_back(e);
  endtask

  task automatic ev(input string tag, input int k,
                    input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    if (sb.size() > 0) e = sb.pop_front();
    else begin e.k = -1; e.a = '0; e.d = '0; end
    chk({tag, "_kind"}, k, e.k);
    chk({tag, "_a"}, a, e.a);
    chk({tag, "_d"}, d, e.d);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory responder plus output monitor
  always @(negedge clk) begin
    logic nack;
    nack = force_ack;
    if (busy) busy_tot++;
    if (reset || !mem_req) wcnt = 0;
    else begin
      if (wcnt == 0) begin
        h_addr = mem_addr; h_wd = mem_wdata; h_we = mem_we;
      end else begin
        chk("hold_addr", mem_addr, h_addr);
        chk("hold_wdata", mem_wdata, h_wd);
        chk("hold_we", 32'(mem_we), 32'(h_we));
      end
      if (wcnt >= dly) begin
        nack = 1'b1;
        n_ack++;
        mem_rdata = rd(mem_addr);
        if (mem_we) begin
          ev("mwr", 0, mem_addr, mem_wdata);
          mem[mem_addr] = mem_wdata;
        end else
          ev("mrd", 1, mem_addr, 32'h0);
        wcnt = 0;
      end else
        wcnt++;
    end
    mem_ack = nack;
    if (rf_we3) begin
      chk("rf_a3_not15", 32'(rf_a3 == 4'd15), 32'h0);
      ev("rfw", 2, 32'(rf_a3), rf_wd3);
      regs[rf_a3] = rf_wd3;
    end
    if (pc_we) ev("pcw", 3, 32'h0, pc_wd);
    if (done) begin
      ev("done", 4, 32'(cyc - start_cyc), 32'(busy_tot - busy0));
      done_cnt++;
    end
  end

  task automatic run(input logic l, input logic w,
                     input logic [3:0] br, input logic [15:0] lst,
                     input logic [31:0] ba, input int d,
                     input bit poke);
    int k, ncyc, d0;
    logic [31:0] a;
    bit wbt;
    k = $countones(lst);
    a = ba;
    dly = d;
    for (int i = 0; i < 16; i++)
      if (lst[i]) begin
        if (!l) push(0, a, regs[i]);
        else begin
          push(1, a, 32'h0);
          if (i == 15) push(3, 32'h0, rd(a) & ~32'd3);
          else push(2, 32'(i), rd(a));
        end
        a = a + 32'd4;
      end
    wbt = w && (br != 4'd15) && !(l && lst[br]) && (lst != '0);
    if (wbt) push(2, 32'(br), ba + 32'(4 * k));
    ncyc = (lst == '0) ? 1 :
           k * (1 + d) + (l ? k : 0) + int'(wbt) + 1;
    push(4, 32'(ncyc), 32'(ncyc));
    @(negedge clk); #1;
    load = l; wb = w; base_reg = br;
    reg_list = lst; base_addr = ba; start = 1'b1;
    start_cyc = cyc; busy0 = busy_tot; d0 = done_cnt;
    @(negedge clk); #1;
    start = 1'b0; reg_list = '0;
    if (poke) begin
      start = 1'b1; reg_list = 16'hffff; load = 1'b0;
      @(negedge clk); #1;
      start = 1'b0; reg_list = '0;
    end
    for (int t = 0; t < 400 && done_cnt == d0; t++) begin
      @(negedge clk); #1;
    end
    chk("done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk); #1;
    chk("idle_busy", 32'(busy), 32'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);
  endtask

  initial begin
    int a0;
    reset = 1'b1; start = 1'b0; load = 1'b0; wb = 1'b0;
    base_reg = '0; base_addr = '0; reg_list = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_req", 32'(mem_req), 32'h0);
    chk("rst_we3", 32'(rf_we3), 32'h0);
    chk("rst_pcwe", 32'(pc_we), 32'h0);

    run(1'b0, 1'b1, 4'd0, 16'h0006, 32'h100, 0, 1'b0);
    run(1'b1, 1'b0, 4'd1, 16'h8011, 32'h200, 0, 1'b0);
    run(1'b1, 1'b1, 4'd3, 16'h0008, 32'h400, 0, 1'b0);
    run(1'b0, 1'b0, 4'd2, 16'h0a05, 32'h300, 3, 1'b0);
    run(1'b0, 1'b1, 4'd0, 16'h0000, 32'h600, 0, 1'b1);
    run(1'b0, 1'b1, 4'd2, 16'h0003, 32'hfffffffc, 0, 1'b0);
    run(1'b0, 1'b1, 4'd15, 16'h00f0, 32'h700, 1, 1'b1);
    run(1'b1, 1'b1, 4'd6, 16'h0021, 32'h800, 2, 1'b0);

    // abort while the second of three stores is pending
    dly = 3;
    push(0, 32'h500, regs[0]);
    @(negedge clk); #1;
    load = 1'b0; wb = 1'b1; base_reg = 4'd1;
    reg_list = 16'h0007; base_addr = 32'h500; start = 1'b1;
    start_cyc = cyc; busy0 = busy_tot; a0 = n_ack;
    @(negedge clk); #1;
    start = 1'b0; reg_list = '0;
    for (int t = 0; t < 100 && n_ack == a0; t++) begin
      @(negedge clk); #1;
    end
    chk("abort_ack1", 32'(n_ack - a0), 32'd1);
    @(negedge clk); #1;
    chk("abort_req_pre", 32'(mem_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("abort_req", 32'(mem_req), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_we3", 32'(rf_we3), 32'h0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0; force_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1 force_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("abort_idle", 32'(busy), 32'h0);
    chk("abort_sb", 32'(sb.size()), 32'h0);
    chk("abort_acks", 32'(n_ack - a0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
